icache: RTL and testbench

// - Instruction-memory responder for the fetch stage. Accepts the 8-byte-aligned fetch address,

---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_array.sv | 60 ++++++
 rtl/icache.sv | 180 ++++++++++++++++++
 tb/tb_icache.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared sizing constants and types for the instruction cache.
// Optional feature macro: ICACHE_PREFETCH_EN (next-line prefetch after a demand fill).
package icache_pkg;

  localparam int XLEN      = 32;
  localparam int NUM_LINES = 32;
  localparam int IDX_W     = $clog2(NUM_LINES);
  localparam int MEM_TAG_W = 4;
  localparam int TAG_W     = XLEN - 3 - IDX_W;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    PF_REQ  = 3'd3,
    PF_WAIT = 3'd4
  } ICACHE_STATE;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      data;
  } ICACHE_LINE;

endpackage

// File: rtl/icache_array.sv
// icache_array: direct-mapped line storage with one combinational read port and one write port.
// Only the valid bits are cleared by reset; tag/data are qualified by valid.
// Optional feature macro: ICACHE_PREFETCH_EN adds a second read port used to probe the next line.
module icache_array
  import icache_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output ICACHE_LINE       rd_line,
`ifdef ICACHE_PREFETCH_EN
  input  logic [IDX_W-1:0] probe_idx,
  output ICACHE_LINE       probe_line,
`endif
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  ICACHE_LINE       wr_line
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] valid_d;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [63:0]          data_mem [NUM_LINES];

  // Next valid vector: a write sets the addressed line's valid bit.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_line.valid;
    end
  end

  // Valid bits are the only stored state that reset must clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage, written on a fill.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_line.tag;
      data_mem[wr_idx] <= wr_line.data;
    end
  end

  assign rd_line.valid = valid_q[rd_idx];
  assign rd_line.tag   = tag_mem[rd_idx];
  assign rd_line.data  = data_mem[rd_idx];

`ifdef ICACHE_PREFETCH_EN
  assign probe_line.valid = valid_q[probe_idx];
  assign probe_line.tag   = tag_mem[probe_idx];
  assign probe_line.data  = data_mem[probe_idx];
`endif

endmodule

// File: rtl/icache.sv
// icache: direct-mapped instruction cache with one outstanding miss, hit-under-miss,
// and same-cycle bypass of fill data to the fetch stage.
// Optional feature macro: ICACHE_PREFETCH_EN (next-line prefetch after each demand fill).
module icache
  import icache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      proc2Icache_addr,
  input  logic                 proc2Icache_req,
  input  logic [MEM_TAG_W-1:0] mem2Icache_response,
  input  logic [63:0]          mem2Icache_data,
  input  logic [MEM_TAG_W-1:0] mem2Icache_tag,
  output logic [63:0]          Icache_data_out,
  output logic                 Icache_valid_out,
  output logic [1:0]           Icache2mem_command,
  output logic [XLEN-1:0]      Icache2mem_addr
);

  ICACHE_STATE          state_q, state_d;
  logic [XLEN-1:0]      miss_addr_q, miss_addr_d;
  logic [MEM_TAG_W-1:0] pending_tag_q, pending_tag_d;
  logic [1:0]           command_q, command_d;
  logic [XLEN-1:0]      mem_addr_q, mem_addr_d;

  ICACHE_LINE           rd_line;
  ICACHE_LINE           wr_line;
  logic                 fill_now;
  logic [XLEN-4:0]      fill_line;
  logic                 hit;
  logic                 bypass;
  logic                 unused_offset;

`ifdef ICACHE_PREFETCH_EN
  logic [MEM_TAG_W-1:0] pf_tag_q, pf_tag_d;
  logic [XLEN-4:0]      pf_line;
  ICACHE_LINE           probe_line;
  logic                 pf_resident;
  logic                 unused_probe_data;
`endif

  // The byte offset within a line never affects lookup.
  assign unused_offset = ^proc2Icache_addr[2:0];

`ifdef ICACHE_PREFETCH_EN
  assign pf_line           = miss_addr_q[XLEN-1:3] + 1'b1;
  assign pf_resident       = probe_line.valid && (probe_line.tag == pf_line[XLEN-4:IDX_W]);
  assign unused_probe_data = ^probe_line.data;
  assign fill_line         = (state_q == PF_WAIT) ? pf_line : miss_addr_q[XLEN-1:3];
`else
  assign fill_line         = miss_addr_q[XLEN-1:3];
`endif

  assign wr_line.valid = 1'b1;
  assign wr_line.tag   = fill_line[XLEN-4:IDX_W];
  assign wr_line.data  = mem2Icache_data;

  icache_array u_array (
    .clock      (clock),
    .reset      (reset),
    .rd_idx     (proc2Icache_addr[3+IDX_W-1:3]),
    .rd_line    (rd_line),
`ifdef ICACHE_PREFETCH_EN
    .probe_idx  (pf_line[IDX_W-1:0]),
    .probe_line (probe_line),
`endif
    .wr_en      (fill_now),
    .wr_idx     (fill_line[IDX_W-1:0]),
    .wr_line    (wr_line)
  );

  assign hit    = proc2Icache_req && rd_line.valid &&
                  (rd_line.tag == proc2Icache_addr[XLEN-1:3+IDX_W]);
  assign bypass = fill_now && proc2Icache_req && (proc2Icache_addr[XLEN-1:3] == fill_line);

  // Fetch response: fill data being written wins over the (pre-write) array content.
  always_comb begin
    Icache_valid_out = 1'b0;
    Icache_data_out  = '0;
    if (bypass) begin
      Icache_valid_out = 1'b1;
      Icache_data_out  = mem2Icache_data;
    end else if (hit) begin
      Icache_valid_out = 1'b1;
      Icache_data_out  = rd_line.data;
    end
  end

  // Miss FSM next-state: launch in IDLE, retry the bus request until accepted, then wait for the tag.
  always_comb begin
    state_d       = state_q;
    miss_addr_d   = miss_addr_q;
    pending_tag_d = pending_tag_q;
    fill_now      = 1'b0;
`ifdef ICACHE_PREFETCH_EN
    pf_tag_d      = pf_tag_q;
`endif
    case (state_q)
      IDLE: begin
        if (proc2Icache_req && !hit) begin
          miss_addr_d = {proc2Icache_addr[XLEN-1:3], 3'b000};
          state_d     = REQ;
        end
      end
      REQ: begin
        if (mem2Icache_response != '0) begin
          pending_tag_d = mem2Icache_response;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        if ((pending_tag_q != '0) && (mem2Icache_tag == pending_tag_q)) begin
          fill_now      = 1'b1;
          pending_tag_d = '0;
`ifdef ICACHE_PREFETCH_EN
          state_d       = pf_resident ? IDLE : PF_REQ;
`else
          state_d       = IDLE;
`endif
        end
      end
`ifdef ICACHE_PREFETCH_EN
      PF_REQ: begin
        if (mem2Icache_response != '0) begin
          pf_tag_d = mem2Icache_response;
          state_d  = PF_WAIT;
        end
      end
      PF_WAIT: begin
        if ((pf_tag_q != '0) && (mem2Icache_tag == pf_tag_q)) begin
          fill_now = 1'b1;
          pf_tag_d = '0;
          state_d  = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    command_d  = BUS_NONE;
    mem_addr_d = mem_addr_q;
    if (state_d == REQ) begin
      command_d  = BUS_LOAD;
      mem_addr_d = miss_addr_d;
    end
`ifdef ICACHE_PREFETCH_EN
    else if (state_d == PF_REQ) begin
      command_d  = BUS_LOAD;
      mem_addr_d = {pf_line, 3'b000};
    end
`endif
  end

  // State, miss bookkeeping and registered bus outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      miss_addr_q   <= '0;
      pending_tag_q <= '0;
      command_q     <= BUS_NONE;
      mem_addr_q    <= '0;
`ifdef ICACHE_PREFETCH_EN
      pf_tag_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      miss_addr_q   <= miss_addr_d;
      pending_tag_q <= pending_tag_d;
      command_q     <= command_d;
      mem_addr_q    <= mem_addr_d;
`ifdef ICACHE_PREFETCH_EN
      pf_tag_q      <= pf_tag_d;
`endif
    end
  end

  assign Icache2mem_command = command_q;
  assign Icache2mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios followed by randomized traffic against a line-address model
// of the cache contents (default build, prefetch disabled).
module tb_icache;
  import icache_pkg::*;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [XLEN-1:0]      proc2Icache_addr = '0;
  logic                 proc2Icache_req = 1'b0;
  logic [MEM_TAG_W-1:0] mem2Icache_response = '0;
  logic [63:0]          mem2Icache_data = '0;
  logic [MEM_TAG_W-1:0] mem2Icache_tag = '0;
  logic [63:0]          Icache_data_out;
  logic                 Icache_valid_out;
  logic [1:0]           Icache2mem_command;
  logic [XLEN-1:0]      Icache2mem_addr;

  int checks = 0;
  int errors = 0;

  // Model: which line address (addr/8) currently lives in each slot, and its data.
  bit          m_present [NUM_LINES];
  int unsigned m_line    [NUM_LINES];
  logic [63:0] m_data    [NUM_LINES];

  icache dut (
    .clock               (clock),
    .reset               (reset),
    .proc2Icache_addr    (proc2Icache_addr),
    .proc2Icache_req     (proc2Icache_req),
    .mem2Icache_response (mem2Icache_response),
    .mem2Icache_data     (mem2Icache_data),
    .mem2Icache_tag      (mem2Icache_tag),
    .Icache_data_out     (Icache_data_out),
    .Icache_valid_out    (Icache_valid_out),
    .Icache2mem_command  (Icache2mem_command),
    .Icache2mem_addr     (Icache2mem_addr)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  function automatic bit modelHit(input logic [XLEN-1:0] a);
    int unsigned ln;
    ln = a >> 3;
    return m_present[ln % NUM_LINES] && (m_line[ln % NUM_LINES] == ln);
  endfunction

  function automatic logic [63:0] modelData(input bit rq, input logic [XLEN-1:0] a);
    int unsigned ln;
    ln = a >> 3;
    if (rq && modelHit(a)) return m_data[ln % NUM_LINES];
    return 64'h0;
  endfunction

  function automatic void modelFill(input logic [XLEN-1:0] a, input logic [63:0] d);
    int unsigned ln;
    ln = a >> 3;
    m_present[ln % NUM_LINES] = 1'b1;
    m_line[ln % NUM_LINES]    = ln;
    m_data[ln % NUM_LINES]    = d;
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < NUM_LINES; i++) m_present[i] = 1'b0;
  endfunction

  function automatic logic [XLEN-1:0] randAddr();
    int unsigned ln;
    ln = $urandom_range(0, 2) * NUM_LINES + $urandom_range(0, 3);
    return (ln * 8) + $urandom_range(0, 7);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input bit rq, input logic [XLEN-1:0] a,
                               input logic [MEM_TAG_W-1:0] resp,
                               input logic [MEM_TAG_W-1:0] mtag,
                               input logic [63:0] mdata);
    proc2Icache_req     = rq;
    proc2Icache_addr    = a;
    mem2Icache_response = resp;
    mem2Icache_tag      = mtag;
    mem2Icache_data     = mdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input bit exp_valid, input logic [63:0] exp_data);
    checks++;
    assert (Icache_valid_out === exp_valid) else begin
      errors++;
      $error("[TB] FAIL %s valid_out: observed=%0b expected=%0b", name, Icache_valid_out, exp_valid);
    end
    checks++;
    assert (Icache_data_out === exp_data) else begin
      errors++;
      $error("[TB] FAIL %s data_out: observed=%h expected=%h", name, Icache_data_out, exp_data);
    end
  endtask

  task automatic checkBus(input string name, input logic [1:0] exp_cmd,
                          input logic [XLEN-1:0] exp_addr, input bit chk_addr);
    checks++;
    assert (Icache2mem_command === exp_cmd) else begin
      errors++;
      $error("[TB] FAIL %s command: observed=%0d expected=%0d", name, Icache2mem_command, exp_cmd);
    end
    if (chk_addr) begin
      checks++;
      assert (Icache2mem_addr === exp_addr) else begin
        errors++;
        $error("[TB] FAIL %s mem_addr: observed=%h expected=%h", name, Icache2mem_addr, exp_addr);
      end
    end
  endtask

  initial begin
    logic [63:0]          d40, d100, fill;
    logic [XLEN-1:0]      a, b, miss_addr;
    logic [MEM_TAG_W-1:0] tagv, wrong;
    int unsigned          line, retries, waits;
    bit                   rq;

    // Reset state.
    modelClear();
    applyStimulus(1'b0, '0, '0, '0, '0);
    checkOutput("reset_out", 1'b0, 64'h0);
    checkBus("reset_bus", BUS_NONE, '0, 1'b1);
    tick();
    tick();
    reset = 1'b1;

    // Scenario 1: cold miss on 0x0.
    applyStimulus(1'b1, 32'h0, '0, '0, '0);
    checkOutput("s1_cold_miss", 1'b0, 64'h0);
    tick();
    checkBus("s1_req", BUS_LOAD, 32'h0, 1'b1);

    // Scenario 2: accepted with tag 3, fill two cycles later, bypass then hit.
    applyStimulus(1'b1, 32'h0, 4'd3, '0, '0);
    tick();
    applyStimulus(1'b1, 32'h0, '0, '0, '0);
    checkOutput("s2_wait_miss", 1'b0, 64'h0);
    checkBus("s2_wait_bus", BUS_NONE, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0, '0, 4'd3, 64'hDEADBEEF_00000013);
    checkOutput("s2_bypass", 1'b1, 64'hDEADBEEF_00000013);
    tick();
    modelFill(32'h0, 64'hDEADBEEF_00000013);
    applyStimulus(1'b1, 32'h4, '0, '0, '0);
    checkOutput("s2_hit", 1'b1, 64'hDEADBEEF_00000013);

    // Scenario 3: three rejected requests, then accepted with tag 5.
    applyStimulus(1'b1, 32'h40, '0, '0, '0);
    checkOutput("s3_miss", 1'b0, 64'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h40, (i == 3) ? 4'd5 : 4'd0, '0, '0);
      checkBus("s3_retry", BUS_LOAD, 32'h40, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 32'h40, '0, '0, '0);
    checkBus("s3_wait", BUS_NONE, '0, 1'b0);
    tick();
    d40 = {$urandom, $urandom};
    applyStimulus(1'b1, 32'h40, '0, 4'd5, d40);
    checkOutput("s3_bypass", 1'b1, d40);
    tick();
    modelFill(32'h40, d40);

    // Scenarios 4/5: hit-under-miss on 0x40 while 0x100 (slot 0) is fetched; stray tag ignored.
    applyStimulus(1'b1, 32'h100, '0, '0, '0);
    checkOutput("s4_miss", 1'b0, 64'h0);
    tick();
    applyStimulus(1'b1, 32'h40, '0, '0, '0);
    checkOutput("s4_hum_req", 1'b1, d40);
    checkBus("s4_req", BUS_LOAD, 32'h100, 1'b1);
    tick();
    applyStimulus(1'b1, 32'h44, 4'd4, '0, '0);
    checkOutput("s4_hum_acc", 1'b1, d40);
    checkBus("s4_req_hold", BUS_LOAD, 32'h100, 1'b1);
    tick();
    d100 = {$urandom, $urandom};
    applyStimulus(1'b1, 32'h40, '0, 4'd2, ~d100);
    checkOutput("s5_stray_tag", 1'b1, d40);
    checkBus("s4_wait", BUS_NONE, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h40, '0, 4'd4, d100);
    checkOutput("s4_hum_fill", 1'b1, d40);
    tick();
    modelFill(32'h100, d100);
    applyStimulus(1'b1, 32'h0, '0, '0, '0);
    checkOutput("s5_evicted", 1'b0, 64'h0);
    applyStimulus(1'b1, 32'h104, '0, '0, '0);
    checkOutput("s5_new_line", 1'b1, d100);
    tick();

    // Scenario 6: reset during WAIT drops the miss; late tag causes no fill.
    applyStimulus(1'b1, 32'h0, '0, '0, '0);
    tick();
    applyStimulus(1'b1, 32'h0, 4'd3, '0, '0);
    checkBus("s6_req", BUS_LOAD, 32'h0, 1'b1);
    tick();
    reset = 1'b0;
    modelClear();
    applyStimulus(1'b1, 32'h0, '0, '0, '0);
    checkOutput("s6_in_reset", 1'b0, 64'h0);
    checkBus("s6_in_reset_bus", BUS_NONE, '0, 1'b1);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, '0, 4'd3, 64'h1234_5678_9ABC_DEF0);
    checkBus("s6_late_tag", BUS_NONE, '0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h0, '0, '0, '0);
    checkOutput("s6_still_miss", 1'b0, 64'h0);
    tick();
    checkBus("s6_new_req", BUS_LOAD, 32'h0, 1'b1);

    // Randomized traffic from a clean cache.
    reset = 1'b0;
    modelClear();
    applyStimulus(1'b0, '0, '0, '0, '0);
    tick();
    reset = 1'b1;
    for (int t = 0; t < 150; t++) begin
      a    = randAddr();
      line = a >> 3;
      applyStimulus(1'b1, a, '0, '0, '0);
      checkOutput("rnd_lookup", modelHit(a), modelData(1'b1, a));
      tick();
      if (!modelHit(a)) begin
        miss_addr = line * 8;
        tagv      = 4'($urandom_range(1, 15));
        retries   = $urandom_range(0, 2);
        for (int r = 0; r <= int'(retries); r++) begin
          b  = randAddr();
          rq = 1'($urandom_range(0, 1));
          applyStimulus(rq, b, (r == int'(retries)) ? tagv : 4'd0, '0, '0);
          checkOutput("rnd_req_hum", rq && modelHit(b), modelData(rq, b));
          checkBus("rnd_req_bus", BUS_LOAD, miss_addr, 1'b1);
          tick();
        end
        waits = $urandom_range(0, 2);
        for (int w = 0; w < int'(waits); w++) begin
          b     = randAddr();
          wrong = 4'($urandom_range(0, 15));
          if (wrong == tagv) wrong = '0;
          applyStimulus(1'b1, b, '0, wrong, {$urandom, $urandom});
          checkOutput("rnd_wait_hum", modelHit(b), modelData(1'b1, b));
          checkBus("rnd_wait_bus", BUS_NONE, '0, 1'b0);
          tick();
        end
        fill = {$urandom, $urandom};
        b    = ($urandom_range(0, 1) == 1) ? a : randAddr();
        applyStimulus(1'b1, b, '0, tagv, fill);
        if ((b >> 3) == line) checkOutput("rnd_bypass", 1'b1, fill);
        else                  checkOutput("rnd_fill_other", modelHit(b), modelData(1'b1, b));
        tick();
        modelFill(miss_addr, fill);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
